// File: rtl/l1_request_arbiter.sv
// l1_request_arbiter: fixed-priority arbiter from the L1 clients onto one
// memory port, with an in-order read-return router driven by an ID FIFO.
module l1_request_arbiter #(
    parameter int L1_CONNECTIONS  = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [L1_CONNECTIONS-1:0]     l1_request,
    output logic [L1_CONNECTIONS-1:0]     l1_ack,
    input  logic [L1_CONNECTIONS*32-1:0]  l1_addr,
    input  logic [L1_CONNECTIONS-1:0]     l1_rnw,
    input  logic [L1_CONNECTIONS*4-1:0]   l1_be,
    input  logic [L1_CONNECTIONS*5-1:0]   l1_size,
    input  logic [L1_CONNECTIONS*32-1:0]  l1_data,
    output logic                          mem_request,
    input  logic                          mem_ack,
    output logic [31:0]                   mem_addr,
    output logic                          mem_rnw,
    output logic [3:0]                    mem_be,
    output logic [4:0]                    mem_size,
    output logic [31:0]                   mem_data,
    input  logic                          mem_rd_data_valid,
    input  logic [31:0]                   mem_rd_data,
    output logic [L1_CONNECTIONS-1:0]     l1_rd_data_valid,
    output logic [31:0]                   l1_rd_data,
    output logic                          rd_underflow
);

    localparam int IDW = (L1_CONNECTIONS > 1) ? $clog2(L1_CONNECTIONS) : 1;
    localparam int PW  = $clog2(MAX_OUTSTANDING);
    localparam int CW  = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic                      r_mem_request;
    logic [31:0]               r_mem_addr;
    logic                      r_mem_rnw;
    logic [3:0]                r_mem_be;
    logic [4:0]                r_mem_size;
    logic [31:0]               r_mem_data;

    logic [IDW-1:0]            r_fifo_id   [MAX_OUTSTANDING];
    logic [4:0]                r_fifo_size [MAX_OUTSTANDING];
    logic [PW-1:0]             r_wr_ptr;
    logic [PW-1:0]             r_rd_ptr;
    logic [CW-1:0]             r_count;
    logic [4:0]                r_word_cnt;
    logic                      r_underflow;

    logic                      w_free;
    logic                      w_full;
    logic                      w_empty;
    logic [L1_CONNECTIONS-1:0] w_eligible;
    logic [L1_CONNECTIONS-1:0] w_grant;
    logic                      w_gnt_any;
    logic [IDW-1:0]            w_gnt_id;
    logic [31:0]               w_sel_addr;
    logic                      w_sel_rnw;
    logic [3:0]                w_sel_be;
    logic [4:0]                w_sel_size;
    logic [31:0]               w_sel_data;
    logic                      w_push;
    logic                      w_hit;
    logic                      w_pop;
    logic [IDW-1:0]            w_head_id;
    logic [4:0]                w_head_size;
    logic [L1_CONNECTIONS-1:0] w_rd_valid;

    assign w_free      = !r_mem_request || mem_ack;
    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_head_id   = r_fifo_id[r_rd_ptr];
    assign w_head_size = r_fifo_size[r_rd_ptr];
    assign w_push      = w_gnt_any && w_sel_rnw;
    assign w_hit       = mem_rd_data_valid && !w_empty;
    assign w_pop       = w_hit && (r_word_cnt == w_head_size);

    // Pick the lowest-index eligible client when the request stage can load
    always_comb begin
        w_eligible = '0;
        w_grant    = '0;
        w_gnt_any  = 1'b0;
        w_gnt_id   = '0;
        w_sel_addr = '0;
        w_sel_rnw  = 1'b0;
        w_sel_be   = '0;
        w_sel_size = '0;
        w_sel_data = '0;
        for (int i = 0; i < L1_CONNECTIONS; i++) begin
            w_eligible[i] = l1_request[i] && (!l1_rnw[i] || !w_full);
            if (w_free && w_eligible[i] && !w_gnt_any) begin
                w_gnt_any  = 1'b1;
                w_grant[i] = 1'b1;
                w_gnt_id   = IDW'(i);
                w_sel_addr = l1_addr[i*32 +: 32];
                w_sel_rnw  = l1_rnw[i];
                w_sel_be   = l1_be[i*4 +: 4];
                w_sel_size = l1_size[i*5 +: 5];
                w_sel_data = l1_data[i*32 +: 32];
            end
        end
    end

    // Route a returning word to the client at the head of the ID FIFO
    always_comb begin
        w_rd_valid = '0;
        for (int i = 0; i < L1_CONNECTIONS; i++) begin
            w_rd_valid[i] = w_hit && (w_head_id == IDW'(i));
        end
    end

    assign l1_ack           = rst_n ? w_grant : '0;
    assign l1_rd_data_valid = rst_n ? w_rd_valid : '0;
    assign l1_rd_data       = mem_rd_data;

    assign mem_request  = r_mem_request;
    assign mem_addr     = r_mem_addr;
    assign mem_rnw      = r_mem_rnw;
    assign mem_be       = r_mem_be;
    assign mem_size     = r_mem_size;
    assign mem_data     = r_mem_data;
    assign rd_underflow = r_underflow;

    // Request stage: load the granted fields, drop valid once accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_request <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_rnw     <= 1'b0;
            r_mem_be      <= '0;
            r_mem_size    <= '0;
            r_mem_data    <= '0;
        end else if (w_gnt_any) begin
            r_mem_request <= 1'b1;
            r_mem_addr    <= w_sel_addr;
            r_mem_rnw     <= w_sel_rnw;
            r_mem_be      <= w_sel_be;
            r_mem_size    <= w_sel_size;
            r_mem_data    <= w_sel_data;
        end else if (mem_ack) begin
            r_mem_request <= 1'b0;
        end
    end

    // ID FIFO storage and pointers; full is taken from the registered count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_OUTSTANDING; k++) begin
                r_fifo_id[k]   <= '0;
                r_fifo_size[k] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_id[r_wr_ptr]   <= w_gnt_id;
                r_fifo_size[r_wr_ptr] <= w_sel_size;
                r_wr_ptr              <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Word counter within the head burst, plus sticky underflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_cnt  <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_pop) begin
                r_word_cnt <= '0;
            end else if (w_hit) begin
                r_word_cnt <= r_word_cnt + 5'd1;
            end
            if (mem_rd_data_valid && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_l1_request_arbiter.sv
// tb_l1_request_arbiter: directed table vectors for grant priority plus
// hand-written sequences for stall, routing, FIFO-full and reset cases.
module tb_l1_request_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   l1_request;
    logic [3:0]   l1_ack;
    logic [127:0] l1_addr;
    logic [3:0]   l1_rnw;
    logic [15:0]  l1_be;
    logic [19:0]  l1_size;
    logic [127:0] l1_data;
    logic         mem_request;
    logic         mem_ack;
    logic [31:0]  mem_addr;
    logic         mem_rnw;
    logic [3:0]   mem_be;
    logic [4:0]   mem_size;
    logic [31:0]  mem_data;
    logic         mem_rd_data_valid;
    logic [31:0]  mem_rd_data;
    logic [3:0]   l1_rd_data_valid;
    logic [31:0]  l1_rd_data;
    logic         rd_underflow;

    int n_cmp = 0;
    int n_err = 0;

    l1_request_arbiter #(
        .L1_CONNECTIONS  (4),
        .MAX_OUTSTANDING (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .l1_request        (l1_request),
        .l1_ack            (l1_ack),
        .l1_addr           (l1_addr),
        .l1_rnw            (l1_rnw),
        .l1_be             (l1_be),
        .l1_size           (l1_size),
        .l1_data           (l1_data),
        .mem_request       (mem_request),
        .mem_ack           (mem_ack),
        .mem_addr          (mem_addr),
        .mem_rnw           (mem_rnw),
        .mem_be            (mem_be),
        .mem_size          (mem_size),
        .mem_data          (mem_data),
        .mem_rd_data_valid (mem_rd_data_valid),
        .mem_rd_data       (mem_rd_data),
        .l1_rd_data_valid  (l1_rd_data_valid),
        .l1_rd_data        (l1_rd_data),
        .rd_underflow      (rd_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  rnw;
        logic [3:0]  ack;
        logic        mreq;
        logic [31:0] addr;
        logic        mrnw;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_client(input int i, input logic rnw,
                              input logic [31:0] a, input logic [4:0] sz);
        l1_rnw[i]            = rnw;
        l1_addr[i*32 +: 32]  = a;
        l1_size[i*5 +: 5]    = sz;
        l1_data[i*32 +: 32]  = a ^ 32'h5A5A_5A5A;
        l1_be[i*4 +: 4]      = 4'hF;
    endtask

    task automatic do_reset();
        l1_request        = '0;
        mem_ack           = 1'b0;
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        rst_n             = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        l1_addr = '0;
        l1_rnw  = '0;
        l1_be   = '0;
        l1_size = '0;
        l1_data = '0;

        vecs[0] = '{4'b1111, 4'b0000, 4'b0001, 1'b1, 32'h1000_0000, 1'b0};
        vecs[1] = '{4'b1110, 4'b1111, 4'b0010, 1'b1, 32'h1000_0100, 1'b1};
        vecs[2] = '{4'b1100, 4'b0100, 4'b0100, 1'b1, 32'h1000_0200, 1'b1};
        vecs[3] = '{4'b1000, 4'b1000, 4'b1000, 1'b1, 32'h1000_0300, 1'b1};
        vecs[4] = '{4'b1010, 4'b0000, 4'b0010, 1'b1, 32'h1000_0100, 1'b0};
        vecs[5] = '{4'b0101, 4'b0001, 4'b0001, 1'b1, 32'h1000_0000, 1'b1};
        vecs[6] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0000_0000, 1'b0};

        // reset state
        do_reset();
        chk("rst_mem_request", {31'd0, mem_request}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_size", {27'd0, mem_size}, 32'd0);
        chk("rst_underflow", {31'd0, rd_underflow}, 32'd0);

        // table: one grant from a freshly reset block
        for (int v = 0; v < 7; v++) begin
            do_reset();
            for (int c = 0; c < 4; c++) begin
                set_client(c, vecs[v].rnw[c], 32'h1000_0000 + 32'(c) * 32'h100,
                           5'd0);
            end
            l1_request = vecs[v].req;
            settle();
            chk($sformatf("vec%0d_ack", v), {28'd0, l1_ack}, {28'd0, vecs[v].ack});
            tick();
            l1_request = '0;
            chk($sformatf("vec%0d_mreq", v), {31'd0, mem_request},
                {31'd0, vecs[v].mreq});
            chk($sformatf("vec%0d_addr", v), mem_addr, vecs[v].addr);
            chk($sformatf("vec%0d_rnw", v), {31'd0, mem_rnw},
                {31'd0, vecs[v].mrnw});
        end

        // single read, client 2, size 3
        do_reset();
        set_client(2, 1'b1, 32'h4000_0100, 5'd3);
        l1_request = 4'b0100;
        settle();
        chk("rd_ack_c0", {28'd0, l1_ack}, 32'h4);
        chk("rd_mreq_c0", {31'd0, mem_request}, 32'd0);
        tick();
        l1_request = '0;
        chk("rd_mreq_c1", {31'd0, mem_request}, 32'd1);
        chk("rd_addr", mem_addr, 32'h4000_0100);
        chk("rd_size", {27'd0, mem_size}, 32'd3);
        chk("rd_rnw", {31'd0, mem_rnw}, 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("rd_mreq_drop", {31'd0, mem_request}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            mem_rd_data_valid = 1'b1;
            mem_rd_data       = 32'hA0 + 32'(k);
            settle();
            chk($sformatf("rd_word%0d_v", k), {28'd0, l1_rd_data_valid}, 32'h4);
            chk($sformatf("rd_word%0d_d", k), l1_rd_data, 32'hA0 + 32'(k));
            tick();
        end
        chk("rd_no_underflow", {31'd0, rd_underflow}, 32'd0);
        mem_rd_data = 32'hEE;
        settle();
        chk("rd_empty_v", {28'd0, l1_rd_data_valid}, 32'd0);
        tick();
        mem_rd_data_valid = 1'b0;
        chk("rd_empty_uf", {31'd0, rd_underflow}, 32'd1);

        // priority: clients 0, 2, 3 together, mem_ack held high
        do_reset();
        set_client(0, 1'b0, 32'h2000_0000, 5'd0);
        set_client(2, 1'b0, 32'h2000_0200, 5'd0);
        set_client(3, 1'b0, 32'h2000_0300, 5'd0);
        mem_ack    = 1'b1;
        l1_request = 4'b1101;
        settle();
        chk("pri_ack0", {28'd0, l1_ack}, 32'h1);
        tick();
        l1_request = 4'b1100;
        settle();
        chk("pri_ack1", {28'd0, l1_ack}, 32'h4);
        chk("pri_addr0", mem_addr, 32'h2000_0000);
        tick();
        l1_request = 4'b1000;
        settle();
        chk("pri_ack2", {28'd0, l1_ack}, 32'h8);
        chk("pri_addr1", mem_addr, 32'h2000_0200);
        tick();
        l1_request = '0;
        chk("pri_addr2", mem_addr, 32'h2000_0300);
        chk("pri_mreq2", {31'd0, mem_request}, 32'd1);
        tick();
        chk("pri_mreq_idle", {31'd0, mem_request}, 32'd0);

        // stall: mem_ack low for 5 cycles with client 0 pending
        do_reset();
        set_client(1, 1'b0, 32'h3000_0100, 5'd0);
        set_client(0, 1'b0, 32'h3000_0000, 5'd0);
        l1_request = 4'b0010;
        settle();
        chk("stall_ack_first", {28'd0, l1_ack}, 32'h2);
        tick();
        l1_request = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            settle();
            chk($sformatf("stall%0d_ack", s), {28'd0, l1_ack}, 32'd0);
            chk($sformatf("stall%0d_addr", s), mem_addr, 32'h3000_0100);
            chk($sformatf("stall%0d_mreq", s), {31'd0, mem_request}, 32'd1);
            tick();
        end
        mem_ack = 1'b1;
        settle();
        chk("stall_release_ack", {28'd0, l1_ack}, 32'h1);
        tick();
        l1_request = '0;
        chk("stall_next_addr", mem_addr, 32'h3000_0000);
        tick();
        mem_ack = 1'b0;

        // interleaved routing: client 3 size 0, then client 0 size 1
        do_reset();
        mem_ack = 1'b1;
        set_client(3, 1'b1, 32'h5000_0300, 5'd0);
        set_client(0, 1'b1, 32'h5000_0000, 5'd1);
        l1_request = 4'b1000;
        tick();
        l1_request = 4'b0001;
        settle();
        chk("il_ack_c0", {28'd0, l1_ack}, 32'h1);
        tick();
        l1_request = '0;
        tick();
        mem_ack           = 1'b0;
        mem_rd_data_valid = 1'b1;
        settle();
        chk("il_w0", {28'd0, l1_rd_data_valid}, 32'h8);
        tick();
        settle();
        chk("il_w1", {28'd0, l1_rd_data_valid}, 32'h1);
        tick();
        settle();
        chk("il_w2", {28'd0, l1_rd_data_valid}, 32'h1);
        tick();
        mem_rd_data_valid = 1'b0;
        chk("il_no_uf", {31'd0, rd_underflow}, 32'd0);

        // FIFO full: 4 reads outstanding, write bypasses a blocked read
        do_reset();
        mem_ack = 1'b1;
        set_client(2, 1'b1, 32'h6000_0200, 5'd0);
        set_client(0, 1'b1, 32'h6000_0000, 5'd0);
        set_client(1, 1'b0, 32'h6000_0100, 5'd0);
        l1_request = 4'b0100;
        for (int r = 0; r < 4; r++) begin
            settle();
            chk($sformatf("full_fill%0d", r), {28'd0, l1_ack}, 32'h4);
            tick();
        end
        l1_request = 4'b0011;
        settle();
        chk("full_write_ack", {28'd0, l1_ack}, 32'h2);
        tick();
        l1_request = 4'b0001;
        chk("full_write_addr", mem_addr, 32'h6000_0100);
        settle();
        chk("full_blocked", {28'd0, l1_ack}, 32'd0);
        tick();
        mem_rd_data_valid = 1'b1;
        settle();
        chk("full_pop_v", {28'd0, l1_rd_data_valid}, 32'h4);
        chk("full_pop_cycle_ack", {28'd0, l1_ack}, 32'd0);
        tick();
        mem_rd_data_valid = 1'b0;
        settle();
        chk("full_after_pop_ack", {28'd0, l1_ack}, 32'h1);
        tick();
        l1_request = '0;
        chk("full_after_pop_addr", mem_addr, 32'h6000_0000);
        tick();
        mem_ack = 1'b0;

        // reset in the middle of a burst
        do_reset();
        mem_ack = 1'b1;
        set_client(1, 1'b1, 32'h7000_0100, 5'd3);
        l1_request = 4'b0010;
        tick();
        l1_request = '0;
        tick();
        mem_ack           = 1'b0;
        mem_rd_data_valid = 1'b1;
        settle();
        chk("mid_w0", {28'd0, l1_rd_data_valid}, 32'h2);
        tick();
        rst_n      = 1'b0;
        l1_request = 4'b0001;
        settle();
        chk("mid_rst_v", {28'd0, l1_rd_data_valid}, 32'd0);
        chk("mid_rst_ack", {28'd0, l1_ack}, 32'd0);
        chk("mid_rst_uf", {31'd0, rd_underflow}, 32'd0);
        tick();
        rst_n      = 1'b1;
        l1_request = '0;
        settle();
        chk("mid_post_v", {28'd0, l1_rd_data_valid}, 32'd0);
        tick();
        mem_rd_data_valid = 1'b0;
        chk("mid_post_uf", {31'd0, rd_underflow}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/l1_request_arbiter.md
# l1_request_arbiter

Arbitrates memory requests from the L1 clients (D-cache, D-MMU, I-cache, I-MMU) onto the single downstream memory/bus port and routes returning read data to the client that issued the request. Sits directly downstream of the L1 clients and upstream of the memory interface. Client indices match the L1 arbiter IDs fixed in the core configuration: D-cache 0, D-MMU 1, I-cache 2, I-MMU 3. Reads return in order; a small ID FIFO tracks outstanding reads.

## Interface
- L1_CONNECTIONS, 4, number of clients; lower index has higher priority.
- MAX_OUTSTANDING, 4, outstanding read bursts tracked (power of 2, ≥2).
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- l1_request  input  [L1_CONNECTIONS]  per-client request valid, held until acked.
- l1_ack  output  [L1_CONNECTIONS]  one-hot capture strobe; request consumed this cycle.
- l1_addr  input  [L1_CONNECTIONS][32]  word-aligned address.
- l1_rnw  input  [L1_CONNECTIONS]  1 = read, 0 = write.
- l1_be  input  [L1_CONNECTIONS][4]  write byte enables.
- l1_size  input  [L1_CONNECTIONS][5]  burst length minus 1, in words; must be 0 for writes.
- l1_data  input  [L1_CONNECTIONS][32]  write data.
- mem_request  output  1  downstream request valid.
- mem_ack  input  1  downstream accepts the current request.
- mem_addr, mem_rnw, mem_be, mem_size, mem_data  output  32/1/4/5/32  registered copy of the granted request.
- mem_rd_data_valid  input  1  one read word returning.
- mem_rd_data  input  32  returned word.
- l1_rd_data_valid  output  [L1_CONNECTIONS]  one-hot read-word strobe to the owning client.
- l1_rd_data  output  32  shared read data, equal to mem_rd_data.
- rd_underflow  output  1  sticky error: read data arrived with no outstanding read.

## Operation
- Request stage: one output register, holding mem_* fields and a valid bit (mem_request).
- The stage is free when mem_request=0, or when mem_request=1 and mem_ack=1.
- Eligible client i: l1_request[i]=1, and if l1_rnw[i]=1 the ID FIFO is not full.
- When the stage is free, the lowest-index eligible client is granted. l1_ack[grant]=1 combinationally that cycle. Its fields load into the stage next edge, and mem_request goes 1.
- On a read grant, {client id, l1_size} is pushed into the ID FIFO in the same edge.
- Ineligible reads (FIFO full) do not block lower-priority writes.
- Return path, combinational:
  - l1_rd_data_valid[head.id] = mem_rd_data_valid && FIFO non-empty.
  - l1_rd_data = mem_rd_data.
- A 5-bit word counter increments on each returned word. When counter == head.size, the FIFO pops and the counter clears.
- mem_rd_data_valid while the FIFO is empty: the word is dropped, no l1_rd_data_valid is asserted, and rd_underflow is set (cleared only by reset).
- Full is derived from the registered count. A pop in the same cycle does not free a slot for a push until the next cycle.
- Push and pop in the same cycle (not full) leave the count unchanged.
- Client requirement: a client's l1_* fields are stable while its l1_request=1 and it is not acked.

## Timing
- Reset (async assert, deassert on clk edge) clears the following:
  - mem_request=0, mem_* fields=0.
  - FIFO empty, counter=0, rd_underflow=0.
  - l1_ack and l1_rd_data_valid forced 0 while rst_n=0.
- Request latency: l1_request in cycle N with a free stage gives l1_ack in cycle N and mem_request=1 in cycle N+1.
- Back-to-back throughput: one request per cycle while mem_ack=1 continuously.
- mem_request holds all fields stable until mem_ack. No new grant occurs while the stage is stalled.
- Read data latency through the block: 0 cycles.
- Reset mid-burst: all outstanding reads are discarded. Words arriving after reset set rd_underflow.

## Test plan
- Single read: client 2 reads addr 0x40000100, size 3. Expect ack in cycle 0, mem_request in cycle 1 with the same fields. Four return words 0xA0..0xA3 assert l1_rd_data_valid=0b0100 four times, then the FIFO is empty.
- Priority: clients 0, 2 and 3 request in the same cycle with mem_ack=1. Expect grants in order 0, 2, 3 on consecutive cycles, with l1_ack one-hot each cycle.
- Stall: mem_ack=0 for 5 cycles. Expect mem_* fields constant, no l1_ack despite pending requests, and the next grant in the cycle mem_ack=1.
- Interleaved routing: client 3 reads (size 0), then client 0 reads (size 1). Expect return words routed to 0b1000 first, then 0b0001 twice.
- FIFO full: 4 reads outstanding, client 0 read pending, client 1 write pending. Expect client 1 write granted and client 0 blocked. After one pop, client 0 is acked the following cycle.
- Underflow/reset: assert rst_n=0 mid-burst, then drive mem_rd_data_valid. Expect no l1_rd_data_valid and rd_underflow=1.
